// File: rtl/fact_seq_ctrl.sv
// fact_seq_ctrl: factorial sequencer for the calculator datapath.
// Computes n! as acc *= k for k = n, n-1, ..., 2. Each multiply step is an
// N_W-cycle shift-add. A product that overflows RES_W bits aborts the run
// with result=0 and ovf=1.
// Optional macro FACT_SEQ_CTRL_ABORT_EN adds a synchronous 'abort' input that
// cancels a running computation. The default build has no abort port.
module fact_seq_ctrl #(
  parameter int N_W   = 9,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
`ifdef FACT_SEQ_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             busy,
  output logic [RES_W-1:0] result,
  output logic             ovf,
  output logic             done
);

  localparam int PW = RES_W + N_W;
  localparam int CW = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CW-1:0]    BIT_LAST = CW'(N_W - 1);
  localparam logic [CW-1:0]    BIT_ONE  = CW'(1);
  localparam logic [N_W-1:0]   K_ONE    = N_W'(1);
  localparam logic [RES_W-1:0] ACC_ONE  = RES_W'(1);
  localparam logic [RES_W-1:0] RES_ZERO = {RES_W{1'b0}};
  localparam logic [PW-1:0]    PART_ZERO = {PW{1'b0}};
  localparam logic [N_W-1:0]   HI_ZERO  = {N_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MUL   = 3'd2,
    S_ACC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [N_W-1:0]   k_q, k_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [PW-1:0]    partial_q, partial_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [PW-1:0]    addend_s;
  logic             abort_s;

`ifdef FACT_SEQ_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // acc shifted into the current multiplier bit position, zero-extended
  assign addend_s = {HI_ZERO, acc_q} << bitcnt_q;

  assign ready  = (state_q == S_IDLE);
  assign busy   = ~ready;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign done   = done_q;

  // Next-state and datapath update; done/result are loaded on entry to DONE
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    partial_d = partial_q;
    bitcnt_d  = bitcnt_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = n;
          acc_d   = ACC_ONE;
          ovf_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (abort_s) begin
          result_d = RES_ZERO;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (k_q <= K_ONE) begin
          result_d = acc_q;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          partial_d = PART_ZERO;
          bitcnt_d  = {CW{1'b0}};
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        if (abort_s) begin
          result_d = RES_ZERO;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          if (k_q[bitcnt_q]) begin
            partial_d = partial_q + addend_s;
          end else begin
            partial_d = partial_q;
          end
          bitcnt_d = bitcnt_q + BIT_ONE;
          if (bitcnt_q == BIT_LAST) begin
            state_d = S_ACC;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_ACC: begin
        if (abort_s) begin
          result_d = RES_ZERO;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (partial_q[PW-1:RES_W] != HI_ZERO) begin
          // product no longer fits: stop the chain, report 0 with ovf
          ovf_d    = 1'b1;
          acc_d    = RES_ZERO;
          result_d = RES_ZERO;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          acc_d   = partial_q[RES_W-1:0];
          k_d     = k_q - K_ONE;
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= {N_W{1'b0}};
      acc_q     <= RES_ZERO;
      partial_q <= PART_ZERO;
      bitcnt_q  <= {CW{1'b0}};
      result_q  <= RES_ZERO;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      partial_q <= partial_d;
      bitcnt_q  <= bitcnt_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fact_seq_ctrl.sv
// Scoreboard bench for fact_seq_ctrl (N_W=9, RES_W=32).
// Latency L counts clock edges with the edge that samples start as edge 1;
// done must be seen high in the cycle following edge L.
module tb_fact_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  n_i;
  logic        ready, busy, ovf, done;
  logic [31:0] result;
`ifdef FACT_SEQ_CTRL_ABORT_EN
  logic        abort;
`endif

  fact_seq_ctrl #(.N_W(9), .RES_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n      (n_i),
`ifdef FACT_SEQ_CTRL_ABORT_EN
    .abort  (abort),
`endif
    .ready  (ready),
    .busy   (busy),
    .result (result),
    .ovf    (ovf),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          exp_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic chk_ready_next = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_ready_next) begin
        check("ready_after_done", {63'd0, ready}, 64'd1);
        chk_ready_next = 1'b0;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", {32'd0, result}, {32'd0, e.res});
          check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
          check("latency", 64'(cyc), 64'(e.exp_cyc));
          check("ready_in_done", {63'd0, ready}, 64'd0);
          chk_ready_next = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 64'd0, 64'd1);
  endtask

  // Issue a start at the first negedge with ready high
  task automatic issue(input logic [8:0] nv, input bit push, input logic [31:0] res,
                       input logic ov, input int lat);
    exp_t e;
    wait_ready();
    start = 1'b1;
    n_i   = nv;
    if (push) begin
      e.res = res; e.ovf = ov; e.exp_cyc = cyc + lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    n_i   = 9'($urandom_range(0, 511));
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_i = 9'd0;
`ifdef FACT_SEQ_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // main vectors; 0 and 1 run back-to-back after 5
    issue(9'd5,  1'b1, 32'd120,       1'b0, 46);
    issue(9'd0,  1'b1, 32'd1,         1'b0, 2);
    issue(9'd1,  1'b1, 32'd1,         1'b0, 2);
    issue(9'd2,  1'b1, 32'd2,         1'b0, 13);
    issue(9'd3,  1'b1, 32'd6,         1'b0, 24);
    issue(9'd7,  1'b1, 32'd5040,      1'b0, 68);
    issue(9'd12, 1'b1, 32'd479001600, 1'b0, 123);
    // 13! overflows in the last step (k=2): DONE follows that ACC
    issue(9'd13, 1'b1, 32'd0,         1'b1, 133);
    drain();

    // start while busy is ignored
    issue(9'd4, 1'b1, 32'd24, 1'b0, 35);
    repeat (5) @(negedge clk);
    start = 1'b1; n_i = 9'd7;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // reset mid-MUL of n=5: no done afterwards
    issue(9'd5, 1'b0, 32'd0, 1'b0, 0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {63'd0, ready}, 64'd1);
    check("midrst_result", {32'd0, result}, 64'd0);
    check("midrst_ovf", {63'd0, ovf}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    repeat (60) @(negedge clk);

`ifdef FACT_SEQ_CTRL_ABORT_EN
    // abort in the third MUL cycle of n=10: DONE on the following edge
    begin
      int c0;
      wait_ready();
      c0 = cyc;
      start = 1'b1; n_i = 9'd10;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 4) @(negedge clk);
      begin
        exp_t e;
        e.res = 32'd0; e.ovf = 1'b0; e.exp_cyc = cyc + 1;
        sb_q.push_back(e);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      drain();
      issue(9'd3, 1'b1, 32'd6, 1'b0, 24);
      drain();
    end
`endif

    issue(9'd6, 1'b1, 32'd720, 1'b0, 57);
    drain();
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
